ldpc_encode_stream: RTL and testbench

Parametrised, streaming successor to the single-shot LDPC encoder. It accepts one K-bit information word per transaction over a valid/ready handshake, together with its K×N generator matrix, and computes codeword = info × G over GF(2). Rows are accumulated PAR per cycle, trading latency for area. The codeword is held on a valid/ready output until it is consumed. It sits between the info-bit source and the channel/modulator stage.

---
 rtl/ldpc_encode_stream.sv | 145 ++++++++++++++
 tb/tb_ldpc_encode_stream.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_encode_stream.sv
// ---------------------------------------------------------------------------
// ldpc_encode_stream
//
// Streaming LDPC encoder. A K-bit information word and its K x N generator
// matrix are accepted over a valid/ready handshake and held internally. The
// codeword = info x G over GF(2) is then built up PAR generator rows per
// cycle. The finished codeword is held on a valid/ready output until the
// downstream stage takes it.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   i_en       global enable; when low every register holds and no
//              handshake completes
//   in_valid   info_bits / generator are valid
//   in_ready   block can accept a new word (IDLE, enabled, not in reset)
//   info_bits  K-bit information word, bit r selects generator row r
//   generator  flattened K x N matrix, row r = generator[(r+1)*N-1 : r*N]
//   out_valid  codeword is valid
//   out_ready  downstream accepts the codeword
//   codeword   N-bit encoded word, kept after out_valid falls
// ---------------------------------------------------------------------------
module ldpc_encode_stream #(
    parameter int N   = 11,
    parameter int K   = 6,
    parameter int PAR = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   info_bits,
    input  logic [K*N-1:0] generator,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   codeword
);

    // Number of accumulation cycles and the counter width that covers them.
    localparam int C  = (K + PAR - 1) / PAR;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [CW-1:0] LAST = CW'(C - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [K-1:0]   info_q, info_d;
    logic [K*N-1:0] gen_q, gen_d;
    logic [N-1:0]   codeword_q, codeword_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   chunk_xor;
    logic [N-1:0]   acc_next;

    assign in_ready  = (state_q == IDLE) && i_en && !rst;
    assign out_valid = out_valid_q;
    assign codeword  = codeword_q;

    // XOR of the selected rows that belong to the current chunk. Every row
    // is tested against the counter, so rows past K in a partial last chunk
    // simply never exist and contribute nothing.
    always_comb begin
        chunk_xor = '0;
        for (int r = 0; r < K; r++) begin
            if (info_q[r] && ((r / PAR) == int'(cnt_q))) begin
                chunk_xor = chunk_xor ^ gen_q[r*N +: N];
            end
        end
    end

    // Next-state logic. Nothing moves while i_en is low. The accept edge
    // snapshots the inputs so later input changes cannot disturb the word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        info_d      = info_q;
        gen_d       = gen_q;
        codeword_d  = codeword_q;
        out_valid_d = out_valid_q;
        acc_next    = acc_q ^ chunk_xor;

        if (i_en) begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        info_d  = info_bits;
                        gen_d   = generator;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_d = acc_next;
                    if (cnt_q == LAST) begin
                        codeword_d  = acc_next;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers. Reset wins over i_en and discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            info_q      <= '0;
            gen_q       <= '0;
            codeword_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            info_q      <= info_d;
            gen_q       <= gen_d;
            codeword_q  <= codeword_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ldpc_encode_stream.sv
// ---------------------------------------------------------------------------
// tb_ldpc_encode_stream
//
// Self-checking bench for ldpc_encode_stream. Two instances run side by side:
// one with PAR=1 (six accumulation cycles) and one with PAR=4 (two cycles,
// last chunk partial). Expected codewords come from a plain row-by-row GF(2)
// matrix product kept in the bench.
// ---------------------------------------------------------------------------
module tb_ldpc_encode_stream;

    localparam int N  = 11;
    localparam int K  = 6;
    localparam int C1 = 6;
    localparam int C4 = 2;
    localparam logic [K*N-1:0] G_SPEC =
        66'b100000101000100001001000100010001000100011000000100101000000101001;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_en;

    logic           in_valid;
    logic           in_ready;
    logic [K-1:0]   info_bits;
    logic [K*N-1:0] generator;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   codeword;

    logic           in_valid4;
    logic           in_ready4;
    logic [K-1:0]   info_bits4;
    logic [K*N-1:0] generator4;
    logic           out_valid4;
    logic           out_ready4;
    logic [N-1:0]   codeword4;

    int total = 0;
    int bad   = 0;
    int cycleNum = 0;

    always #5 clk = ~clk;

    // Free-running edge count, used to measure spacing between accepts.
    always @(posedge clk) cycleNum <= cycleNum + 1;

    ldpc_encode_stream #(.N(N), .K(K), .PAR(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .info_bits (info_bits),
        .generator (generator),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeword  (codeword)
    );

    ldpc_encode_stream #(.N(N), .K(K), .PAR(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .info_bits (info_bits4),
        .generator (generator4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .codeword  (codeword4)
    );

    // Reference: XOR of every generator row whose info bit is set.
    function automatic logic [N-1:0] refEncode(input logic [K-1:0] info,
                                               input logic [K*N-1:0] gen);
        logic [N-1:0] res;
        res = '0;
        for (int r = 0; r < K; r++) begin
            if (info[r]) res = res ^ gen[r*N +: N];
        end
        return res;
    endfunction

    function automatic logic [K*N-1:0] randVec();
        logic [K*N-1:0] v;
        for (int i = 0; i < K*N; i++) v[i] = (($urandom & 1) != 0);
        return v;
    endfunction

    // Advance one edge and settle past it before anything is sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts, and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one word to the PAR=1 instance, scramble the inputs right after
    // the accept, optionally drop i_en for a few cycles mid-accumulation,
    // then check latency and codeword.
    task automatic applyStimulus(input logic [K-1:0] info, input logic [K*N-1:0] gen,
                                 input int stallAt, input int stallLen,
                                 input string tag, output int acceptCycle);
        int waitCnt;
        int edges;
        int stallLeft;
        logic [K*N-1:0] junk;
        waitCnt = 0;
        while (!in_ready && waitCnt < 40) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        info_bits = info;
        generator = gen;
        tick();
        acceptCycle = cycleNum;
        in_valid  = 1'b0;
        junk      = randVec();
        info_bits = junk[K-1:0];
        generator = randVec();
        edges     = 0;
        stallLeft = stallLen;
        while (!out_valid && edges < 60) begin
            if (stallLeft > 0 && edges == stallAt) begin
                i_en = 1'b0;
                repeat (stallLeft) begin
                    tick();
                    edges++;
                end
                i_en = 1'b1;
                stallLeft = 0;
            end else begin
                tick();
                edges++;
            end
        end
        checkOutput({tag, "_lat"}, 64'(edges), 64'(C1 + stallLen));
        checkOutput({tag, "_cw"}, 64'(codeword), 64'(refEncode(info, gen)));
    endtask

    // With out_ready high, one edge retires the word: out_valid drops,
    // in_ready returns and the codeword keeps its value.
    task automatic checkRelease(input string tag, input logic [N-1:0] expCw);
        tick();
        checkOutput({tag, "_ovlow"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_irdy"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_keep"}, 64'(codeword), 64'(expCw));
    endtask

    // Same flow for the PAR=4 instance, always with out_ready4 high.
    task automatic applyStimulus4(input logic [K-1:0] info, input logic [K*N-1:0] gen,
                                  input string tag);
        int waitCnt;
        int edges;
        waitCnt = 0;
        while (!in_ready4 && waitCnt < 40) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, "_rdy"}, 64'(in_ready4), 64'd1);
        in_valid4  = 1'b1;
        info_bits4 = info;
        generator4 = gen;
        tick();
        in_valid4  = 1'b0;
        info_bits4 = ~info;
        generator4 = randVec();
        edges = 0;
        while (!out_valid4 && edges < 60) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_lat"}, 64'(edges), 64'(C4));
        checkOutput({tag, "_cw"}, 64'(codeword4), 64'(refEncode(info, gen)));
        tick();
        checkOutput({tag, "_ovlow"}, 64'(out_valid4), 64'd0);
        checkOutput({tag, "_irdy"}, 64'(in_ready4), 64'd1);
    endtask

    initial begin
        int acc;
        int prevAcc;
        int k;
        logic [K*N-1:0] rv;
        logic [K-1:0] ri;
        logic [N-1:0] held;

        rst        = 1'b1;
        i_en       = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        info_bits  = '0;
        generator  = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        info_bits4 = '0;
        generator4 = '0;

        // Reset state
        repeat (2) tick();
        checkOutput("rst_ov", 64'(out_valid), 64'd0);
        checkOutput("rst_cw", 64'(codeword), 64'd0);
        checkOutput("rst_irdy_inrst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_irdy", 64'(in_ready), 64'd1);
        checkOutput("rst_irdy4", 64'(in_ready4), 64'd1);

        // All rows selected, known answer
        applyStimulus(6'b111111, G_SPEC, 0, 0, "t1", acc);
        checkOutput("t1_known", 64'(codeword), 64'(11'b11111111000));
        checkRelease("t1", 11'b11111111000);

        // All-zero word still takes the full latency
        applyStimulus(6'b000000, G_SPEC, 0, 0, "zero", acc);
        checkRelease("zero", 11'b0);

        // Backpressure: outputs hold and new words are refused
        out_ready = 1'b0;
        applyStimulus(6'b101010, G_SPEC, 0, 0, "bp", acc);
        held = refEncode(6'b101010, G_SPEC);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            rv        = randVec();
            info_bits = rv[K-1:0];
            generator = randVec();
            tick();
            checkOutput("bp_ov", 64'(out_valid), 64'd1);
            checkOutput("bp_cw", 64'(codeword), 64'(held));
            checkOutput("bp_irdy", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkRelease("bp", held);
        tick();
        checkOutput("bp_noaccept", 64'(out_valid), 64'd0);

        // Enable low for 3 cycles mid-accumulation
        applyStimulus(6'b111111, G_SPEC, 2, 3, "stall", acc);
        checkRelease("stall", 11'b11111111000);

        // Reset during accumulation discards the word
        in_valid  = 1'b1;
        info_bits = 6'b111111;
        generator = G_SPEC;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checkOutput("mrst_ov", 64'(out_valid), 64'd0);
        checkOutput("mrst_cw", 64'(codeword), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("mrst_irdy", 64'(in_ready), 64'd1);
        repeat (8) tick();
        checkOutput("mrst_quiet", 64'(out_valid), 64'd0);
        applyStimulus(6'b000001, G_SPEC, 0, 0, "mrst", acc);
        checkOutput("mrst_known", 64'(codeword), 64'(11'b00000101001));
        checkRelease("mrst", 11'b00000101001);

        // Back-to-back stream of 4 words, one accept every 8 edges
        prevAcc = 0;
        for (int w = 0; w < 4; w++) begin
            rv = randVec();
            ri = rv[K-1:0];
            rv = randVec();
            applyStimulus(ri, rv, 0, 0, "strm", acc);
            if (w > 0) checkOutput("strm_gap", 64'(acc - prevAcc), 64'd8);
            prevAcc = acc;
            checkRelease("strm", refEncode(ri, rv));
        end

        // Random words with random stalls and backpressure
        for (int w = 0; w < 12; w++) begin
            rv = randVec();
            ri = rv[K-1:0];
            rv = randVec();
            k = $urandom_range(0, 3);
            out_ready = (k == 0);
            applyStimulus(ri, rv, $urandom_range(0, 5), $urandom_range(0, 2), "rnd", acc);
            repeat (k) tick();
            checkOutput("rnd_hold", 64'(codeword), 64'(refEncode(ri, rv)));
            out_ready = 1'b1;
            checkRelease("rnd", refEncode(ri, rv));
        end

        // PAR=4 instance: partial last chunk
        applyStimulus4(6'b000001, G_SPEC, "p4a");
        checkOutput("p4a_known", 64'(codeword4), 64'(11'b00000101001));
        applyStimulus4(6'b100000, G_SPEC, "p4b");
        checkOutput("p4b_known", 64'(codeword4), 64'(11'b10000010100));
        applyStimulus4(6'b111111, G_SPEC, "p4c");
        checkOutput("p4c_known", 64'(codeword4), 64'(11'b11111111000));
        for (int w = 0; w < 8; w++) begin
            rv = randVec();
            ri = rv[K-1:0];
            applyStimulus4(ri, randVec(), "p4r");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
